mul_sequencer: RTL and testbench



---
 rtl/mul_sequencer.sv | 175 +++++++++++++++++
 tb/tb_mul_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_sequencer.sv
// Operand FIFO and handshake sequencer for the repeated-addition multiplier.
// Drives start/data in the multiplier's expected cycle order and returns results over valid/ready.
module mul_sequencer #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 2**WIDTH + 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  output logic                   mul_start,
  output logic [WIDTH-1:0]       mul_data_in,
  output logic                   mul_rst,
  input  logic                   mul_done,
  input  logic [WIDTH-1:0]       mul_product,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_product,
  output logic                   out_err,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = WIDTH + 2;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_LOAD_A,
    S_LOAD_B,
    S_WAIT,
    S_CLR,
    S_OUT
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             push, pop;
  logic             fifo_empty, head_zero, timed_out;
  logic [WIDTH-1:0] head_a, head_b;
  logic [TW-1:0]    timer;
  logic [WIDTH-1:0] res_q;
  logic             err_q;
  logic             mul_rst_q;

  assign in_ready    = (count < FULL_CNT);
  assign push        = in_valid && in_ready;
  assign fifo_empty  = (count == '0);
  assign fifo_count  = count;
  assign head_a      = mem_a[rd_ptr];
  assign head_b      = mem_b[rd_ptr];
  assign head_zero   = (head_a == '0) || (head_b == '0);
  assign timed_out   = (timer == TMO_LAST);
  assign out_product = res_q;
  assign out_err     = err_q;
  assign mul_rst     = mul_rst_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          // Zero operands never reach the multiplier: b==0 would hang its control path.
          if (head_zero) begin
            pop      = 1'b1;
            state_nx = S_OUT;
          end else begin
            state_nx = S_START;
          end
        end
      end
      S_START:  state_nx = S_LOAD_A;
      S_LOAD_A: state_nx = S_LOAD_B;
      S_LOAD_B: state_nx = S_WAIT;
      S_WAIT: begin
        if (mul_done || timed_out) begin
          pop      = 1'b1;
          state_nx = S_CLR;
        end
      end
      S_CLR: state_nx = S_OUT;
      S_OUT: if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    mul_start   = 1'b0;
    mul_data_in = '0;
    out_valid   = 1'b0;
    case (state)
      S_START: begin
        mul_start   = 1'b1;
        mul_data_in = head_a;
      end
      S_LOAD_A:       mul_data_in = head_a;
      S_LOAD_B,
      S_WAIT:         mul_data_in = head_b;
      S_OUT:          out_valid   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (state == S_LOAD_B) begin
      timer <= '0;
    end else if (state == S_WAIT && timer != '1) begin
      timer <= timer + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q <= '0;
      err_q <= 1'b0;
    end else if (state == S_IDLE && pop) begin
      res_q <= '0;
      err_q <= 1'b0;
    end else if (state == S_WAIT && mul_done) begin
      res_q <= mul_product;
      err_q <= 1'b0;
    end else if (state == S_WAIT && timed_out) begin
      res_q <= '0;
      err_q <= 1'b1;
    end
  end

  // Held high through reset and asserted for the single CLR cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mul_rst_q <= 1'b1;
    else     mul_rst_q <= (state_nx == S_CLR);
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: behavioural multiplier plus a result scoreboard computed from a*b mod 2^16.
module tb_mul_sequencer;

  localparam int unsigned W  = 16;
  localparam int unsigned D  = 4;
  localparam int unsigned TO = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] in_a, in_b;
  logic         mul_start, mul_rst, mul_done;
  logic [W-1:0] mul_data_in, mul_product;
  logic         out_valid, out_ready, out_product_err_unused;
  logic [W-1:0] out_product;
  logic         out_err;
  logic [2:0]   fifo_count;

  int compared   = 0;
  int mismatched = 0;

  mul_sequencer #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_start(mul_start), .mul_data_in(mul_data_in), .mul_rst(mul_rst),
    .mul_done(mul_done), .mul_product(mul_product),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .out_err(out_err), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: captures a then b after start, reports a*b after min(b,15) add cycles.
  bit           hold_done = 1'b0;
  logic [W-1:0] ma = '0, mb = '0;
  logic         mul_done_r = 1'b0;
  logic [W-1:0] mul_product_r = '0;
  int           mphase = 0, mcnt = 0, mlat = 1;
  assign mul_done    = mul_done_r;
  assign mul_product = mul_product_r;
  assign out_product_err_unused = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mphase     <= 0;
      mul_done_r <= 1'b0;
    end else if (mul_rst) begin
      mphase     <= 0;
      mul_done_r <= 1'b0;
    end else begin
      case (mphase)
        0: if (mul_start) mphase <= 1;
        1: begin ma <= mul_data_in; mphase <= 2; end
        2: begin
          mb     <= mul_data_in;
          mlat   <= (mul_data_in > 16'd15) ? 15 : int'(mul_data_in);
          mcnt   <= 0;
          mphase <= 3;
        end
        3: begin
          mcnt <= mcnt + 1;
          if (!hold_done && mcnt == mlat - 1) begin
            mul_product_r <= ma * mb;
            mul_done_r    <= 1'b1;
            mphase        <= 4;
          end
        end
        default: ;
      endcase
    end
  end

  int n_start = 0, n_mulrst = 0, start_cyc = 0, done_cyc = 0, valid_cyc = 0;
  logic done_prev = 1'b0, ov_prev = 1'b0;
  always @(negedge clk) begin
    if (mul_start) begin n_start++; start_cyc = cyc; end
    if (mul_rst && !rst) n_mulrst++;
    if (mul_done && !done_prev) done_cyc = cyc;
    if (out_valid && !ov_prev) valid_cyc = cyc;
    done_prev = mul_done;
    ov_prev   = out_valid;
  end

  logic [16:0] exp_q[$];
  int push_cyc = 0;

  function automatic logic [15:0] ref_prod(input logic [15:0] a, input logic [15:0] b);
    longint unsigned p;
    if (a == 16'd0 || b == 16'd0) return 16'd0;
    p = 64'(a) * 64'(b);
    return 16'(p % 64'd65536);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b, input bit to);
    int n = 0;
    while (!in_ready && n < 200) begin tick(); n++; end
    check("push_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    push_cyc = cyc;
    tick();
    in_valid = 1'b0;
    exp_q.push_back(to ? {1'b1, 16'h0000} : {1'b0, ref_prod(a, b)});
  endtask

  task automatic get_result(input string tag);
    logic [16:0] e;
    int n = 0;
    out_ready = 1'b1;
    while (!out_valid && n < 300) begin tick(); n++; end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    e = 17'h1ffff;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    check({tag, "_product"}, 32'(out_product), 32'(e[15:0]));
    check({tag, "_err"}, 32'(out_err), 32'(e[16]));
    @(posedge clk);
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] ra, rb;
    int s_start, s_rst, n;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    tick(); tick();
    check("rst_mul_rst",    32'(mul_rst),     32'd1);
    check("rst_in_ready",   32'(in_ready),    32'd1);
    check("rst_out_valid",  32'(out_valid),   32'd0);
    check("rst_fifo_count", 32'(fifo_count),  32'd0);
    check("rst_mul_start",  32'(mul_start),   32'd0);
    check("rst_data_in",    32'(mul_data_in), 32'd0);
    check("rst_product",    32'(out_product), 32'd0);
    check("rst_err",        32'(out_err),     32'd0);
    rst = 1'b0;
    tick();
    check("rst_release_mul_rst", 32'(mul_rst), 32'd0);

    // Basic multiply 3x4
    s_start = n_start; s_rst = n_mulrst;
    push(16'd3, 16'd4, 1'b0);
    get_result("basic");
    check("basic_start_pulses", 32'(n_start - s_start), 32'd1);
    check("basic_loada_data",   32'(ma), 32'd3);
    check("basic_loadb_data",   32'(mb), 32'd4);
    check("basic_mul_rst",      32'(n_mulrst - s_rst), 32'd1);
    check("basic_start_time",   32'(start_cyc), 32'(push_cyc + 2));
    check("basic_valid_time",   32'(valid_cyc), 32'(done_cyc + 2));

    // Zero bypass
    s_start = n_start;
    push(16'd7, 16'd0, 1'b0);
    get_result("bypass1");
    check("bypass1_time", 32'(valid_cyc), 32'(push_cyc + 2));
    push(16'd0, 16'd9, 1'b0);
    get_result("bypass2");
    check("bypass2_time", 32'(valid_cyc), 32'(push_cyc + 2));
    check("bypass_no_start", 32'(n_start - s_start), 32'd0);
    check("bypass_count", 32'(fifo_count), 32'd0);

    // FIFO full and wrap
    out_ready = 1'b0;
    push(16'd2, 16'd2, 1'b0);
    push(16'd3, 16'd5, 1'b0);
    push(16'd7, 16'd9, 1'b0);
    push(16'd1, 16'd11, 1'b0);
    check("full_in_ready_4", 32'(in_ready), 32'd0);
    check("full_count_4", 32'(fifo_count), 32'd4);
    push(16'd13, 16'd13, 1'b0);
    tick(); tick();
    check("full_count_after_pop", 32'(fifo_count), 32'd4);
    check("full_in_ready_after_pop", 32'(in_ready), 32'd0);
    fork
      begin
        push(16'd200, 16'd3, 1'b0);
        push(16'd0, 16'd5, 1'b0);
        push(16'd255, 16'd255, 1'b0);
        push(16'd65535, 16'd2, 1'b0);
        push(16'd17, 16'd0, 1'b0);
        push(16'd1000, 16'd60, 1'b0);
      end
      begin
        for (int i = 0; i < 11; i++) get_result("wrap");
      end
    join
    check("wrap_count", 32'(fifo_count), 32'd0);

    // Backpressure: result held while a second pair waits
    out_ready = 1'b0;
    push(16'd6, 16'd7, 1'b0);
    push(16'd4, 16'd4, 1'b0);
    n = 0;
    while (!out_valid && n < 300) begin tick(); n++; end
    s_start = n_start;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid",   32'(out_valid),   32'd1);
      check("bp_product", 32'(out_product), 32'(ref_prod(16'd6, 16'd7)));
      check("bp_err",     32'(out_err),     32'd0);
      check("bp_no_start", 32'(n_start), 32'(s_start));
    end
    get_result("bp1");
    get_result("bp2");

    // Timeout
    hold_done = 1'b1;
    s_rst = n_mulrst;
    push(16'd9, 16'd9, 1'b1);
    get_result("timeout");
    check("timeout_wait_len", 32'(valid_cyc - start_cyc), 32'(4 + TO));
    check("timeout_mul_rst",  32'(n_mulrst - s_rst), 32'd1);
    hold_done = 1'b0;
    push(16'd2, 16'd3, 1'b0);
    get_result("after_timeout");

    // Reset during WAIT
    hold_done = 1'b1;
    s_start = n_start;
    push(16'd10, 16'd10, 1'b0);
    push(16'd11, 16'd11, 1'b0);
    push(16'd12, 16'd12, 1'b0);
    n = 0;
    while (n_start == s_start && n < 50) begin tick(); n++; end
    check("midrst_started", 32'(n_start - s_start), 32'd1);
    for (int i = 0; i < 5; i++) tick();
    check("midrst_count_before", 32'(fifo_count), 32'd3);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid),  32'd0);
    check("midrst_count",     32'(fifo_count), 32'd0);
    check("midrst_mul_rst",   32'(mul_rst),    32'd1);
    check("midrst_data_in",   32'(mul_data_in), 32'd0);
    tick(); tick();
    rst = 1'b0;
    exp_q.delete();
    hold_done = 1'b0;
    tick();
    check("midrst_release_mul_rst", 32'(mul_rst), 32'd0);
    push(16'd5, 16'd5, 1'b0);
    get_result("after_reset");

    // Randomized pairs
    for (int i = 0; i < 12; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(1, 40));
      if (i % 4 == 3) ra = 16'd0;
      if (i % 5 == 2) rb = 16'd0;
      push(ra, rb, 1'b0);
      get_result("rand");
      if (ra == 16'd0 || rb == 16'd0) begin
        check("rand_bypass_time", 32'(valid_cyc), 32'(push_cyc + 2));
      end else begin
        check("rand_start_time", 32'(start_cyc), 32'(push_cyc + 2));
        check("rand_valid_time", 32'(valid_cyc), 32'(done_cyc + 2));
      end
    end
    check("final_count", 32'(fifo_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
